// File: rtl/adc_pulse_gen.sv
// Synthetic detector-pulse source: linear-rise / exponential-decay pulses with pile-up on a baseline.
// Latency: trigger sampled at edge N -> pulse_start after N, adc_data shows env one edge after env moves.
// Backpressure: none; free-running sample stream, triggers arriving during a rise are dropped.
module adc_pulse_gen #(
    parameter int DATA_W      = 12,
    parameter int FRAC        = 8,
    parameter int RISE_LOG2   = 2,
    parameter int DECAY_SHIFT = 4,
    parameter int PERIOD_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trig_mode,
    input  logic                     fire,
    input  logic [DATA_W-2:0]        amplitude,
    input  logic signed [DATA_W-1:0] baseline,
    input  logic [PERIOD_W-1:0]      period,
    output logic signed [DATA_W-1:0] adc_data,
    output logic                     pulse_start,
    output logic                     busy
);

    // Envelope is unsigned Q(DATA_W).FRAC so a piled-up pulse can exceed full scale
    // before the output saturates.
    localparam int ENV_W = DATA_W + FRAC;
    localparam int RC_W  = RISE_LOG2 + 1;
    // Baseline plus a piled-up envelope can reach ~3x full scale; two guard bits keep
    // the sum exact so the clip decision is always right.
    localparam int SUM_W = DATA_W + 2;

    localparam logic [RC_W-1:0]         RISE_LAST  = RC_W'((2 ** RISE_LOG2) - 1);
    localparam logic [RC_W-1:0]         RC_ONE     = RC_W'(1);
    localparam logic [PERIOD_W-1:0]     PERIOD_ONE = PERIOD_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MAX    = SUM_W'((2 ** (DATA_W - 1)) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RISE  = 2'd1,
        ST_DECAY = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ENV_W-1:0]         env_q, env_d;
    logic [ENV_W-1:0]         step_q, step_d;
    logic [RC_W-1:0]          rise_cnt_q, rise_cnt_d;
    logic [PERIOD_W-1:0]      cnt_q, cnt_d;
    logic signed [DATA_W-1:0] adc_data_q, adc_data_d;
    logic                     pulse_start_q, pulse_start_d;

    logic                     period_on;
    logic                     period_hit;
    logic                     trig_req;
    logic                     accept;
    logic [PERIOD_W-1:0]      period_m1;
    logic [ENV_W-1:0]         amp_step;
    logic [ENV_W:0]           rise_sum;
    logic [ENV_W-1:0]         env_rise;
    logic [ENV_W-1:0]         env_decay;
    logic [DATA_W-1:0]        env_int;
    logic signed [SUM_W-1:0]  adc_sum;

    // Trigger decode: a pulse can start from IDLE or on top of a decaying tail, never mid-rise.
    assign period_m1  = period - PERIOD_ONE;
    assign period_on  = !trig_mode && (period != '0);
    assign period_hit = period_on && (cnt_q == period_m1);
    assign trig_req   = enable && (trig_mode ? fire : period_hit);
    assign accept     = trig_req && (state_q != ST_RISE);

    // Per-edge rise increment so that 2**RISE_LOG2 steps add exactly amp<<FRAC.
    assign amp_step   = (ENV_W'(amplitude) << FRAC) >> RISE_LOG2;

    // Rise adds with saturation at all-ones; decay removes a fixed fraction each edge.
    assign rise_sum   = {1'b0, env_q} + {1'b0, step_q};
    assign env_rise   = rise_sum[ENV_W] ? '1 : rise_sum[ENV_W-1:0];
    assign env_decay  = env_q - (env_q >> DECAY_SHIFT);

    // Integer part of the envelope, added to the signed baseline with guard bits.
    assign env_int    = env_q[ENV_W-1:FRAC];
    assign adc_sum    = SUM_W'(baseline) + $signed({2'b00, env_int});

    // Period counter: free-runs 0..period-1, wraps at the end or at once if period shrank below it.
    always_comb begin
        cnt_d = cnt_q + PERIOD_ONE;
        if (!period_on || accept || (cnt_q >= period_m1)) begin
            cnt_d = '0;
        end
    end

    // Output stage: clip the sample to full scale (envelope is never negative, so only the top clips).
    always_comb begin
        adc_data_d    = adc_sum[DATA_W-1:0];
        pulse_start_d = accept;
        if (adc_sum > SAT_MAX) begin
            adc_data_d = SAT_MAX[DATA_W-1:0];
        end
    end

    // Pulse FSM: IDLE -> RISE for 2**RISE_LOG2 steps -> DECAY until the integer part hits zero.
    always_comb begin
        state_d    = state_q;
        env_d      = env_q;
        step_d     = step_q;
        rise_cnt_d = rise_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_RISE;
                    step_d     = amp_step;
                    rise_cnt_d = '0;
                end
            end
            ST_RISE: begin
                env_d      = env_rise;
                rise_cnt_d = rise_cnt_q + RC_ONE;
                if (rise_cnt_q == RISE_LAST) begin
                    state_d = ST_DECAY;
                end
            end
            ST_DECAY: begin
                if (accept) begin
                    // Pile-up: the residual tail is kept and the new rise stacks on it.
                    state_d    = ST_RISE;
                    step_d     = amp_step;
                    rise_cnt_d = '0;
                end else if (env_int == '0) begin
                    // Drop the sub-LSB remainder so the next pulse starts from a clean zero.
                    state_d = ST_IDLE;
                    env_d   = '0;
                end else begin
                    env_d = env_decay;
                end
            end
            default: begin
                state_d = ST_IDLE;
                env_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any pulse in flight immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            env_q         <= '0;
            step_q        <= '0;
            rise_cnt_q    <= '0;
            cnt_q         <= '0;
            adc_data_q    <= '0;
            pulse_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            env_q         <= env_d;
            step_q        <= step_d;
            rise_cnt_q    <= rise_cnt_d;
            cnt_q         <= cnt_d;
            adc_data_q    <= adc_data_d;
            pulse_start_q <= pulse_start_d;
        end
    end

    assign adc_data    = adc_data_q;
    assign pulse_start = pulse_start_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_pulse_gen.sv
// Bench for adc_pulse_gen: directed scenarios plus random traffic against a behavioural model.
// Timing: inputs change 1ns after a rising edge, outputs are checked at the same point.
// Flow control: none; the model advances once per rising edge.
module tb_adc_pulse_gen;

    localparam int     DATA_W   = 12;
    localparam longint ENV_MAX  = (longint'(1) << 20) - 1;   // 20-bit envelope, 1/256 LSB units
    localparam int     PH_IDLE  = 0;
    localparam int     PH_RISE  = 1;
    localparam int     PH_DECAY = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic                     trig_mode;
    logic                     fire;
    logic [DATA_W-2:0]        amplitude;
    logic signed [DATA_W-1:0] baseline;
    logic [15:0]              period;
    logic signed [DATA_W-1:0] adc_data;
    logic                     pulse_start;
    logic                     busy;

    int vec  = 0;
    int errs = 0;

    // Reference model state: pulse phase, envelope in 1/256 LSB, rise steps remaining.
    int     m_phase;
    longint m_env;
    longint m_step;
    int     m_rise_left;
    int     m_cnt;
    int     m_adc;
    logic   m_ps;
    logic   m_busy;

    always #5 clk = ~clk;

    adc_pulse_gen #(
        .DATA_W(12), .FRAC(8), .RISE_LOG2(2), .DECAY_SHIFT(4), .PERIOD_W(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .trig_mode(trig_mode), .fire(fire),
        .amplitude(amplitude), .baseline(baseline), .period(period),
        .adc_data(adc_data), .pulse_start(pulse_start), .busy(busy)
    );

    function automatic void model_reset();
        m_phase = PH_IDLE; m_env = 0; m_step = 0; m_rise_left = 0;
        m_cnt = 0; m_adc = 0; m_ps = 1'b0; m_busy = 1'b0;
    endfunction

    // One rising edge of the behavioural model, using the inputs present at that edge.
    function automatic void model_edge();
        int per;
        int lvl;
        bit hit;
        bit acc;
        if (!reset) begin
            model_reset();
            return;
        end
        per = int'(period);
        hit = !trig_mode && per != 0 && m_cnt == per - 1;
        acc = enable && (trig_mode ? fire : hit) && m_phase != PH_RISE;
        lvl = int'(baseline) + int'(m_env / 256);
        m_adc = (lvl > 2047) ? 2047 : ((lvl < -2048) ? -2048 : lvl);
        m_ps = acc;
        if (trig_mode || per == 0 || m_cnt >= per - 1) m_cnt = 0;
        else m_cnt = m_cnt + 1;
        if (acc) begin
            m_phase = PH_RISE;
            m_rise_left = 4;
            m_step = longint'(amplitude) * 64;       // amp * 256 / 4
        end else if (m_phase == PH_RISE) begin
            m_env = (m_env + m_step > ENV_MAX) ? ENV_MAX : m_env + m_step;
            m_rise_left = m_rise_left - 1;
            if (m_rise_left == 0) m_phase = PH_DECAY;
        end else if (m_phase == PH_DECAY) begin
            if (m_env < 256) begin
                m_phase = PH_IDLE;
                m_env = 0;
            end else begin
                m_env = m_env - m_env / 16;
            end
        end
        m_busy = (m_phase != PH_IDLE);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; trig_mode = 1'b1; fire = 1'b0;
        amplitude = '0; baseline = '0; period = '0;
        model_reset();
        repeat (3) tick();
        vec++; if (adc_data !== 12'sd0) begin errs++; $display("FAIL reset_adc: got %0d want 0", adc_data); end
        vec++; if (pulse_start !== 1'b0) begin errs++; $display("FAIL reset_strobe: got %b want 0", pulse_start); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b1;
        baseline = -12'sd50;
        tick();
        vec++; if (adc_data !== -12'sd50) begin errs++; $display("FAIL reset_baseline: got %0d want -50", adc_data); end
        repeat (4) begin
            tick();
            vec++;
            if (adc_data !== 12'(m_adc) || busy !== 1'b0 || pulse_start !== m_ps) begin
                errs++;
                $display("FAIL reset_idle: got adc=%0d busy=%b want adc=%0d busy=0", adc_data, busy, m_adc);
            end
        end
    endtask

    task automatic test_single_shot();
        int exp_adc[8];
        int n;
        exp_adc = '{0, 400, 800, 1200, 1600, 1500, 1406, 1318};
        baseline = '0; amplitude = 11'd1600; trig_mode = 1'b1; enable = 1'b1;
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        vec++; if (pulse_start !== 1'b1 || busy !== 1'b1) begin errs++; $display("FAIL ss_strobe: got ps=%b busy=%b want 1 1", pulse_start, busy); end
        for (int k = 0; k < 8; k++) begin
            tick();
            vec++;
            if (adc_data !== 12'(exp_adc[k])) begin
                errs++;
                $display("FAIL ss_shape[%0d]: got %0d want %0d", k, adc_data, exp_adc[k]);
            end
            if (k == 0) begin
                vec++; if (pulse_start !== 1'b0) begin errs++; $display("FAIL ss_strobe_len: got %b want 0", pulse_start); end
            end
        end
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
            vec++;
            if (adc_data !== 12'(m_adc) || pulse_start !== m_ps || busy !== m_busy) begin
                errs++;
                $display("FAIL ss_decay: got adc=%0d ps=%b busy=%b want adc=%0d ps=%b busy=%b",
                         adc_data, pulse_start, busy, m_adc, m_ps, m_busy);
            end
        end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL ss_timeout: busy=%b after %0d cycles want 0", busy, n); end
    endtask

    task automatic test_saturation();
        int max_seen;
        int min_seen;
        int n;
        bit all_min;
        baseline = 12'sd2000; amplitude = 11'd200; trig_mode = 1'b1; enable = 1'b1;
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        max_seen = -5000; min_seen = 5000; n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
            if (int'(adc_data) > max_seen) max_seen = int'(adc_data);
            if (int'(adc_data) < min_seen) min_seen = int'(adc_data);
            vec++;
            if (adc_data !== 12'(m_adc) || busy !== m_busy) begin
                errs++;
                $display("FAIL sat_model: got adc=%0d busy=%b want adc=%0d busy=%b", adc_data, busy, m_adc, m_busy);
            end
        end
        vec++; if (max_seen != 2047) begin errs++; $display("FAIL sat_top: got peak %0d want 2047", max_seen); end
        vec++; if (min_seen != 2000) begin errs++; $display("FAIL sat_nowrap: got min %0d want 2000", min_seen); end
        baseline = -12'sd2048; amplitude = '0;
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        all_min = 1'b1;
        repeat (10) begin
            tick();
            if (adc_data !== -12'sd2048) all_min = 1'b0;
        end
        vec++; if (!all_min) begin errs++; $display("FAIL sat_bottom: got %0d want -2048", adc_data); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL sat_zero_amp_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_periodic();
        int strobes[$];
        int late;
        int n;
        baseline = -12'sd200; amplitude = 11'd1000; enable = 1'b1;
        trig_mode = 1'b0; period = 16'd100;
        for (int i = 1; i <= 450; i++) begin
            tick();
            if (pulse_start === 1'b1) strobes.push_back(i);
            if (i == 105) begin
                vec++; if (adc_data !== 12'sd800) begin errs++; $display("FAIL per_peak: got %0d want 800", adc_data); end
            end
            vec++;
            if (adc_data !== 12'(m_adc) || pulse_start !== m_ps || busy !== m_busy) begin
                errs++;
                $display("FAIL per_model: got adc=%0d ps=%b busy=%b want adc=%0d ps=%b busy=%b",
                         adc_data, pulse_start, busy, m_adc, m_ps, m_busy);
            end
        end
        vec++; if (strobes.size() != 4) begin errs++; $display("FAIL per_count: got %0d strobes want 4", strobes.size()); end
        for (int j = 0; j < strobes.size(); j++) begin
            vec++;
            if (strobes[j] != 100 * (j + 1)) begin
                errs++;
                $display("FAIL per_spacing[%0d]: got cycle %0d want %0d", j, strobes[j], 100 * (j + 1));
            end
        end
        period = '0;
        late = 0; n = 0;
        repeat (300) begin
            tick();
            if (pulse_start === 1'b1) late++;
            vec++;
            if (adc_data !== 12'(m_adc) || busy !== m_busy) begin
                errs++;
                $display("FAIL per_off_model: got adc=%0d busy=%b want adc=%0d busy=%b", adc_data, busy, m_adc, m_busy);
            end
        end
        vec++; if (late != 0) begin errs++; $display("FAIL per_off: got %0d strobes want 0", late); end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL per_off_idle: got busy=%b want 0", busy); end
        trig_mode = 1'b1;
    endtask

    task automatic test_pileup();
        int n;
        baseline = -12'sd1000; amplitude = 11'd1600; trig_mode = 1'b1; enable = 1'b1;
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            fire = (k == 2 || k == 7);
            tick();
            fire = 1'b0;
            vec++;
            if (adc_data !== 12'(m_adc) || pulse_start !== m_ps || busy !== m_busy) begin
                errs++;
                $display("FAIL pile_model[%0d]: got adc=%0d ps=%b busy=%b want adc=%0d ps=%b busy=%b",
                         k, adc_data, pulse_start, busy, m_adc, m_ps, m_busy);
            end
            if (k == 2) begin
                vec++; if (pulse_start !== 1'b0) begin errs++; $display("FAIL pile_rise_ignored: got ps=%b want 0", pulse_start); end
            end
            if (k == 7) begin
                vec++; if (pulse_start !== 1'b1) begin errs++; $display("FAIL pile_accept: got ps=%b want 1", pulse_start); end
            end
            if (k == 12) begin
                vec++; if (adc_data !== 12'sd2006) begin errs++; $display("FAIL pile_peak: got %0d want 2006", adc_data); end
            end
        end
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            tick();
            n++;
        end
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL pile_timeout: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit clean;
        baseline = '0; amplitude = 11'd1600; trig_mode = 1'b1; enable = 1'b1;
        tick();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        repeat (10) tick();
        vec++;
        if (adc_data !== 12'(m_adc) || int'(adc_data) < 1000) begin
            errs++;
            $display("FAIL mid_level: got %0d want %0d", adc_data, m_adc);
        end
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        vec++; if (adc_data !== 12'sd0) begin errs++; $display("FAIL mid_async_adc: got %0d want 0", adc_data); end
        vec++; if (busy !== 1'b0 || pulse_start !== 1'b0) begin errs++; $display("FAIL mid_async_ctl: got busy=%b ps=%b want 0 0", busy, pulse_start); end
        repeat (2) tick();
        reset = 1'b1;
        clean = 1'b1;
        repeat (20) begin
            tick();
            if (adc_data !== 12'sd0 || busy !== 1'b0) clean = 1'b0;
        end
        vec++; if (!clean) begin errs++; $display("FAIL mid_no_tail: got adc=%0d busy=%b want 0 0", adc_data, busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                trig_mode = 1'($urandom_range(0, 1));
                period = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(8, 150));
            end
            if ($urandom_range(0, 49) == 0) baseline = 12'($urandom_range(0, 4095));
            enable = ($urandom_range(0, 9) != 0);
            fire = ($urandom_range(0, 39) == 0);
            amplitude = 11'($urandom_range(0, 2047));
            tick();
            vec++;
            if (adc_data !== 12'(m_adc) || pulse_start !== m_ps || busy !== m_busy) begin
                errs++;
                $display("FAIL rand_model[%0d]: got adc=%0d ps=%b busy=%b want adc=%0d ps=%b busy=%b",
                         i, adc_data, pulse_start, busy, m_adc, m_ps, m_busy);
            end
        end
        fire = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_saturation();
        test_periodic();
        test_pileup();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
